// File: rtl/tx_sequencer_1553.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tx_sequencer_1553 : buffers 1553 words and paces them into the encoder.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tx_sequencer_1553 #(
  parameter int DEPTH    = 8,
  parameter int GAP_CLKS = 8
) (
  input  logic                   enc_clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [15:0]            wr_word,
  input  logic                   wr_csw,
  input  logic                   wr_last,
  output logic                   wr_full,
  output logic [$clog2(DEPTH):0] fifo_level,
  input  logic                   seq_en,
  input  logic                   tx_busy,
  output logic [15:0]            tx_dword,
  output logic                   tx_csw,
  output logic                   tx_dw,
  output logic                   seq_active,
  output logic                   msg_done,
  output logic                   underrun,
  output logic                   ovf_err,
  output logic                   enc_err
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [7:0]  GAP_LOAD = 8'(GAP_CLKS - 1);
  localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_END   = 3'd3,
    S_GAP        = 3'd4
  } state_e;

  logic [17:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          ovf_q;
  state_e        state_q, state_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic [7:0]    gap_q, gap_d;
  logic          last_q, last_d;
  logic          discard_q, discard_d;
  logic [15:0]   tx_dword_q, tx_dword_d;
  logic          tx_csw_q, tx_csw_d;
  logic          tx_dw_q, tx_dw_d;
  logic          msg_done_q, msg_done_d;
  logic          underrun_q, underrun_d;
  logic          enc_err_q, enc_err_d;
  logic          push, pop, empty;
  logic [17:0]   head;

  assign wr_full    = (level_q == LVL_FULL);
  assign empty      = (level_q == '0);
  assign push       = wr_en & ~wr_full;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_level = level_q;

  // Entry layout: {last, csw, word}
  always_ff @(posedge enc_clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_last, wr_csw, wr_word};
  end

  always_ff @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= wr_en & wr_full;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + (AW + 1)'(1);
      else if (pop && !push) level_q <= level_q - (AW + 1)'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    wcnt_d     = wcnt_q;
    gap_d      = gap_q;
    last_d     = last_q;
    discard_d  = discard_q;
    tx_dword_d = tx_dword_q;
    tx_csw_d   = 1'b0;
    tx_dw_d    = 1'b0;
    msg_done_d = 1'b0;
    underrun_d = 1'b0;
    enc_err_d  = 1'b0;

    // Flush the tail of a message whose word the encoder never accepted.
    if (discard_q && !empty) begin
      pop = 1'b1;
      if (head[17]) discard_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (seq_en && !empty && !discard_q) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        pop        = 1'b1;
        tx_dword_d = head[15:0];
        tx_csw_d   = head[16];
        tx_dw_d    = ~head[16];
        last_d     = head[17];
        wcnt_d     = 2'd0;
        state_d    = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (tx_busy) begin
          state_d = S_WAIT_END;
        end else if (wcnt_q == 2'd3) begin
          enc_err_d = 1'b1;
          discard_d = ~last_q;
          gap_d     = GAP_LOAD;
          state_d   = S_GAP;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      S_WAIT_END: begin
        if (!tx_busy) begin
          if (last_q) begin
            msg_done_d = 1'b1;
            gap_d      = GAP_LOAD;
            state_d    = S_GAP;
          end else if (!empty) begin
            state_d = S_ISSUE;
          end else begin
            underrun_d = 1'b1;
            gap_d      = GAP_LOAD;
            state_d    = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 8'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wcnt_q     <= 2'd0;
      gap_q      <= 8'd0;
      last_q     <= 1'b0;
      discard_q  <= 1'b0;
      tx_dword_q <= 16'h0000;
      tx_csw_q   <= 1'b0;
      tx_dw_q    <= 1'b0;
      msg_done_q <= 1'b0;
      underrun_q <= 1'b0;
      enc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      gap_q      <= gap_d;
      last_q     <= last_d;
      discard_q  <= discard_d;
      tx_dword_q <= tx_dword_d;
      tx_csw_q   <= tx_csw_d;
      tx_dw_q    <= tx_dw_d;
      msg_done_q <= msg_done_d;
      underrun_q <= underrun_d;
      enc_err_q  <= enc_err_d;
    end
  end

  assign tx_dword   = tx_dword_q;
  assign tx_csw     = tx_csw_q;
  assign tx_dw      = tx_dw_q;
  assign seq_active = (state_q != S_IDLE);
  assign msg_done   = msg_done_q;
  assign underrun   = underrun_q;
  assign ovf_err    = ovf_q;
  assign enc_err    = enc_err_q;

endmodule
`default_nettype wire
